// File: rtl/sm_bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Results saturate to all nines with an overflow flag when the value exceeds the digit count.
module sm_bin_to_bcd #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    scratch_q;
  logic             sticky_q;
  logic [CW-1:0]    count_q;

  logic [BW-1:0]    corrected;
  logic [BW-1:0]    scratch_next;
  logic             sticky_next;
  logic             last_bit;

  // One iteration: per-digit add-3 without inter-digit carry, then shift in the next input bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    corrected = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[d*4 +: 4] >= 4'd5)
        corrected[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
    end
    scratch_next = {corrected[BW-2:0], shift_q[WIDTH-1]};
    sticky_next  = sticky_q | corrected[BW-1];
    last_bit     = (count_q == CW'(1));
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CONV;
      CONV:    if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output.
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Datapath and held result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      count_q   <= '0;
      out_valid <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_q   <= in_data;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            count_q   <= CW'(WIDTH);
          end
        end
        CONV: begin
          shift_q   <= shift_q << 1;
          scratch_q <= scratch_next;
          sticky_q  <= sticky_next;
          count_q   <= count_q - CW'(1);
          if (last_bit) begin
            out_valid <= 1'b1;
            overflow  <= sticky_next;
            bcd       <= sticky_next ? {DIGITS{4'h9}} : scratch_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_bin_to_bcd.sv
// Self-checking bench for sm_bin_to_bcd: vector table, corner-case sequences and
// randomized values compared against a decimal-arithmetic reference model.
module tb_sm_bin_to_bcd;

  localparam int WIDTH  = 27;
  localparam int DIGITS = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DIGITS*4-1:0] bcd;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  sm_bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [31:0]      exp_bcd;
    logic             exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, saturation by magnitude comparison.
  function automatic void model(input longint unsigned v, output logic [31:0] b, output logic o);
    longint unsigned p = 1;
    b = '0;
    o = (v > 64'd99_999_999);
    if (o) begin
      b = 32'h9999_9999;
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        b[d*4 +: 4] = 4'((v / p) % 10);
        p = p * 10;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one value, return result, observed latency and protocol-violation counts.
  task automatic run_conv(input logic [WIDTH-1:0] v, output logic [31:0] b, output logic o,
                          output int lat, output int ready_bad, output logic extra_pulse);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid  = 1'b0;
    in_data   = '0;
    lat       = 0;
    ready_bad = 0;
    while (lat < 200) begin
      if (out_valid) break;
      if (in_ready !== 1'b0) ready_bad++;
      tick();
      lat++;
    end
    b = bcd;
    o = overflow;
    tick();
    extra_pulse = out_valid;
  endtask

  // Cycles from now until out_valid is seen, bounded.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 200);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] b, eb;
    logic        o, eo, extra;
    int          lat, rbad, n, pulses, changes;
    logic [WIDTH-1:0] rv;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_bcd", 64'(bcd), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);

    vecs.push_back('{27'd0,           32'h0000_0000, 1'b0});
    vecs.push_back('{27'd12_345_678,  32'h1234_5678, 1'b0});
    vecs.push_back('{27'd99_999_999,  32'h9999_9999, 1'b0});
    vecs.push_back('{27'd100_000_000, 32'h9999_9999, 1'b1});
    vecs.push_back('{27'd134_217_727, 32'h9999_9999, 1'b1});
    vecs.push_back('{27'd9,           32'h0000_0009, 1'b0});
    vecs.push_back('{27'd10_000_000,  32'h1000_0000, 1'b0});
    vecs.push_back('{27'd4095,        32'h0000_4095, 1'b0});
    vecs.push_back('{27'd5,           32'h0000_0005, 1'b0});

    foreach (vecs[i]) begin
      run_conv(vecs[i].data, b, o, lat, rbad, extra);
      check($sformatf("vec%0d_bcd", i), 64'(b), 64'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_ovf", i), 64'(o), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(WIDTH));
      check($sformatf("vec%0d_ready_low", i), 64'(rbad), 64'd0);
      check($sformatf("vec%0d_single_pulse", i), 64'(extra), 64'd0);
    end

    // Result held through a long idle stretch.
    run_conv(27'd12_345_678, b, o, lat, rbad, extra);
    changes = 0;
    for (int c = 0; c < 100; c++) begin
      if (bcd !== 32'h1234_5678 || overflow !== 1'b0 || out_valid !== 1'b0) changes++;
      tick();
    end
    check("hold_100_cycles", 64'(changes), 64'd0);

    // Back-to-back with in_valid held high: 1, 10, 255.
    in_valid = 1'b1;
    in_data  = 27'd1;
    tick();
    in_data = 27'd10;
    wait_out(n);
    check("b2b_first_latency", 64'(n), 64'(WIDTH));
    check("b2b_first_bcd", 64'(bcd), 64'h0000_0001);
    check("b2b_ready_with_valid", 64'(in_ready), 64'd1);
    tick();
    in_data = 27'd255;
    n = 1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check("b2b_second_spacing", 64'(n), 64'(WIDTH + 1));
    check("b2b_second_bcd", 64'(bcd), 64'h0000_0010);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    n = 1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check("b2b_third_spacing", 64'(n), 64'(WIDTH + 1));
    check("b2b_third_bcd", 64'(bcd), 64'h0000_0255);
    tick();

    // Inputs ignored during conversion.
    in_valid = 1'b1;
    in_data  = 27'd4096;
    tick();
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 5) begin
        in_valid = 1'b1;
        in_data  = 27'd5;
      end
      if (c == 15) begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      if (out_valid) pulses++;
      tick();
    end
    check("ignore_pulses", 64'(pulses), 64'd1);
    check("ignore_bcd", 64'(bcd), 64'h0000_4096);

    // Reset mid-conversion aborts without a result.
    in_valid = 1'b1;
    in_data  = 27'd777;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) pulses++;
      tick();
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    run_conv(27'd42, b, o, lat, rbad, extra);
    check("after_abort_bcd", 64'(b), 64'h0000_0042);
    check("after_abort_latency", 64'(lat), 64'(WIDTH));

    // Randomized values against the reference model.
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) rv = WIDTH'($urandom_range(0, 134_217_727));
      else if (k % 3 == 1) rv = WIDTH'($urandom_range(0, 99_999_999));
      else rv = WIDTH'($urandom_range(0, 9999));
      model(64'(rv), eb, eo);
      run_conv(rv, b, o, lat, rbad, extra);
      check($sformatf("rand%0d_bcd(%0d)", k, rv), 64'(b), 64'(eb));
      check($sformatf("rand%0d_ovf(%0d)", k, rv), 64'(o), 64'(eo));
      check($sformatf("rand%0d_latency", k), 64'(lat), 64'(WIDTH));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
